// File: rtl/gate_tester_if.sv
// Signal bundle between the gate tester and its harness: run control, gate
// drive/response and the result outputs.
interface gate_tester_if;
  logic       start;
  logic       y;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;

  // The tester drives the gate and reports results.
  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_count, fail_vec
  );

  // The harness requests runs, returns the gate output and reads the results.
  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/gate_tester.sv
// Sweeps a 2-input gate through all four input vectors for PASSES sweeps and
// checks each response against the truth table TT (bit index = {a,b}).
module gate_tester #(
  parameter logic [3:0] TT     = 4'b1000,
  parameter int         SETTLE = 2,
  parameter int         PASSES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  gate_tester_if.master        bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
  localparam logic [7:0] LAST_PASS   = 8'(PASSES - 1);

  state_t     state_q, state_d;
  logic [3:0] settle_cnt;
  logic [1:0] idx;
  logic [7:0] pass_cnt;
  logic       a_q, b_q;
  logic       busy_q, done_q, pass_q;
  logic [7:0] err_q;
  logic [3:0] fail_q;

  logic       mismatch;
  logic       last_vec;
  logic [7:0] err_next;

  assign mismatch = bus.y ^ TT[{a_q, b_q}];
  assign last_vec = (idx == 2'd3) && (pass_cnt == LAST_PASS);
  assign err_next = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SETTLE;
      S_SETTLE: if (settle_cnt == 4'd1) state_d = S_SAMPLE;
      S_SAMPLE: state_d = last_vec ? S_IDLE : S_SETTLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      idx        <= '0;
      pass_cnt   <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            idx        <= '0;
            pass_cnt   <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            err_q      <= '0;
            fail_q     <= '0;
            pass_q     <= 1'b0;
            busy_q     <= 1'b1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: settle_cnt <= settle_cnt - 4'd1;
        S_SAMPLE: begin
          err_q      <= err_next;
          settle_cnt <= SETTLE_LOAD;
          if (mismatch) fail_q[{a_q, b_q}] <= 1'b1;
          if (idx != 2'd3) begin
            idx        <= idx + 2'd1;
            {a_q, b_q} <= idx + 2'd1;
          end else if (!last_vec) begin
            pass_cnt   <= pass_cnt + 8'd1;
            idx        <= '0;
            {a_q, b_q} <= 2'b00;
          end else begin
            // Final vector: a/b keep 11, verdict includes this edge's compare.
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (err_next == 8'd0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule
